// File: rtl/enc8to3_if.sv
// Handshake bundle for the 8-to-3 sequential event encoder: capture inputs,
// consumer ready, and the registered index/status outputs.
interface enc8to3_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic [7:0]       in;
   logic             rdy;
   logic [2:0]       out;
   logic             vld;
   logic [7:0]       pending;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   modport master (input en, in, rdy, output out, vld, pending, ovf, cnt);
   modport slave  (output en, in, rdy, input out, vld, pending, ovf, cnt);
endinterface

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 event encoder: latches multi-hot strobes into a pending set and
// issues one index per valid/ready handshake. ENC8TO3_ROUND_ROBIN_EN enables rotating priority.
module enc8to3_seq #(
   parameter int CNT_W = 8
) (
   input  logic      clk,
   input  logic      rst,
   enc8to3_if.master bus
);
   typedef enum logic {IDLE, PRESENT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       pending_r, pend_kept, pend_nxt, clr_mask, cap;
   logic [2:0]       out_r, out_nxt, base;
   logic             vld_r, vld_nxt, ovf_r, acc;
   logic [CNT_W-1:0] cnt_r;

   // First set bit of p searched upward from last+1, wrapping; last=7 gives lowest-first.
   function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] last);
      logic [2:0] idx;
      logic [2:0] c;
      logic       found;
      idx   = 3'd0;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         c = last + 3'(k);
         if (!found && p[c]) begin
            idx   = c;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   assign acc       = vld_r & bus.rdy;
   assign clr_mask  = acc ? (8'd1 << out_r) : 8'd0;
   assign pend_kept = pending_r & ~clr_mask;
   assign cap       = bus.en ? bus.in : 8'd0;
   assign pend_nxt  = pend_kept | cap;

`ifdef ENC8TO3_ROUND_ROBIN_EN
   logic [2:0] last_r;

   // On an accepted handshake the index just served becomes the new search origin.
   assign base = acc ? out_r : last_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_r <= 3'd7;
      else if (acc)
         last_r <= out_r;
   end
`else
   assign base = 3'd7;
`endif

   always_comb begin
      state_nxt = state;
      out_nxt   = out_r;
      vld_nxt   = vld_r;
      case (state)
         IDLE: begin
            vld_nxt = 1'b0;
            if (pending_r != 8'd0) begin
               out_nxt   = pick(pending_r, base);
               vld_nxt   = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            // New strobes only join the search after they land in pending.
            if (bus.rdy) begin
               if (pend_kept != 8'd0) begin
                  out_nxt = pick(pend_kept, base);
               end else begin
                  vld_nxt   = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_r     <= 3'd0;
         vld_r     <= 1'b0;
         pending_r <= 8'd0;
         ovf_r     <= 1'b0;
         cnt_r     <= '0;
      end else begin
         state     <= state_nxt;
         out_r     <= out_nxt;
         vld_r     <= vld_nxt;
         pending_r <= pend_nxt;
         if (bus.en && ((bus.in & pend_kept) != 8'd0))
            ovf_r <= 1'b1;
         if (acc && (cnt_r != {CNT_W{1'b1}}))
            cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign bus.out     = out_r;
   assign bus.vld     = vld_r;
   assign bus.pending = pending_r;
   assign bus.ovf     = ovf_r;
   assign bus.cnt     = cnt_r;
endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: vector table, hand sequences for hold/overflow/reset,
// and random traffic against a set-based reference model.
module tb_enc8to3_seq;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;

   // reference model state
   int m_pending, m_out, m_vld, m_ovf, m_cnt, m_last;

   enc8to3_if #(.CNT_W(CNT_W)) bus ();

   enc8to3_seq #(.CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] in;
      logic       rdy;
      logic       exp_vld;
      logic [2:0] exp_out;
      logic [7:0] exp_pend;
      int         exp_cnt;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int m_pick(input int p, input int last);
      for (int k = 1; k <= 8; k++) begin
         int c;
         c = (last + k) % 8;
         if (((p >> c) & 1) != 0) return c;
      end
      return 0;
   endfunction

   function automatic int search_origin();
`ifdef ENC8TO3_ROUND_ROBIN_EN
      return m_last;
`else
      return 7;
`endif
   endfunction

   task automatic model_reset();
      m_pending = 0; m_out = 0; m_vld = 0; m_ovf = 0; m_cnt = 0; m_last = 7;
   endtask

   task automatic model_step(input int en, input int in, input int rdy);
      int acc, clr, kept;
      acc  = (m_vld != 0 && rdy != 0) ? 1 : 0;
      clr  = acc ? (1 << m_out) : 0;
      kept = m_pending & ~clr & 8'hFF;
      if (en != 0 && (in & kept) != 0) m_ovf = 1;
      if (acc) begin
         if (m_cnt < CNT_MAX) m_cnt++;
         m_last = m_out;
      end
      if (m_vld == 0) begin
         if (m_pending != 0) begin
            m_out = m_pick(m_pending, search_origin());
            m_vld = 1;
         end
      end else if (acc) begin
         if (kept != 0) m_out = m_pick(kept, search_origin());
         else m_vld = 0;
      end
      m_pending = kept | (en != 0 ? in : 0);
   endtask

   task automatic cyc(input logic en, input logic [7:0] in, input logic rdy);
      bus.en  = en;
      bus.in  = in;
      bus.rdy = rdy;
      @(posedge clk);
      model_step(int'(en), int'(in), int'(rdy));
      #1;
      check("vld", int'(bus.vld), m_vld);
      check("pending", int'(bus.pending), m_pending);
      check("ovf", int'(bus.ovf), m_ovf);
      check("cnt", int'(bus.cnt), m_cnt);
      if (m_vld != 0) check("out", int'(bus.out), m_out);
   endtask

   task automatic do_reset();
      bus.en = 1'b0; bus.in = 8'd0; bus.rdy = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("rst_vld", int'(bus.vld), 0);
      check("rst_out", int'(bus.out), 0);
      check("rst_pending", int'(bus.pending), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_cnt", int'(bus.cnt), 0);
   endtask

   initial begin
      bus.en = 1'b0; bus.in = 8'd0; bus.rdy = 1'b0;
      model_reset();

      // single event then multi-hot burst
      tbl[0] = '{1'b1, 8'h20, 1'b1, 1'b0, 3'd0, 8'h20, 0};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20, 0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1};
      tbl[4] = '{1'b1, 8'h8A, 1'b1, 1'b0, 3'd0, 8'h8A, 1};
`ifdef ENC8TO3_ROUND_ROBIN_EN
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h8A, 1};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h0A, 2};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h08, 3};
`else
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h8A, 1};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h88, 2};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80, 3};
`endif
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].en, tbl[i].in, tbl[i].rdy);
         check($sformatf("tbl%0d_vld", i), int'(bus.vld), int'(tbl[i].exp_vld));
         check($sformatf("tbl%0d_pending", i), int'(bus.pending), int'(tbl[i].exp_pend));
         check($sformatf("tbl%0d_cnt", i), int'(bus.cnt), tbl[i].exp_cnt);
         if (tbl[i].exp_vld) check($sformatf("tbl%0d_out", i), int'(bus.out), int'(tbl[i].exp_out));
      end

      // backpressure: index 3 held while a lower event arrives
      do_reset();
      cyc(1'b1, 8'h08, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      check("hold_out_a", int'(bus.out), 3);
      cyc(1'b1, 8'h01, 1'b0);
      check("hold_out_b", int'(bus.out), 3);
      cyc(1'b0, 8'h00, 1'b0);
      check("hold_out_c", int'(bus.out), 3);
      check("hold_vld", int'(bus.vld), 1);
      cyc(1'b0, 8'h00, 1'b1);
      check("hold_next", int'(bus.out), 0);
      cyc(1'b0, 8'h00, 1'b1);
      check("hold_drain", int'(bus.vld), 0);

      // overflow and set-wins-over-clear
      do_reset();
      cyc(1'b1, 8'h04, 1'b0);
      check("ovf_clear", int'(bus.ovf), 0);
      cyc(1'b1, 8'h04, 1'b0);
      check("ovf_set", int'(bus.ovf), 1);
      cyc(1'b1, 8'h04, 1'b1);
      check("setwins_pend", int'(bus.pending[2]), 1);
      cyc(1'b0, 8'h00, 1'b1);
      check("setwins_reissue", int'(bus.out), 2);
      check("setwins_vld", int'(bus.vld), 1);
      cyc(1'b0, 8'h00, 1'b1);
      check("ovf_sticky", int'(bus.ovf), 1);

      // asynchronous reset mid-stream
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      check("pre_rst_vld", int'(bus.vld), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_vld", int'(bus.vld), 0);
      check("arst_pending", int'(bus.pending), 0);
      check("arst_cnt", int'(bus.cnt), 0);
      check("arst_ovf", int'(bus.ovf), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      check("post_rst_idle", int'(bus.vld), 0);

`ifdef ENC8TO3_ROUND_ROBIN_EN
      do_reset();
      cyc(1'b1, 8'hFF, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      check("rr_first", int'(bus.out), 0);
      cyc(1'b1, 8'h03, 1'b1);
      check("rr_after_restrobe", int'(bus.out), 1);
      for (int k = 2; k <= 8; k++) begin
         cyc(1'b0, 8'h00, 1'b1);
         check($sformatf("rr_seq%0d", k), int'(bus.out), k % 8);
      end
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic       r_en, r_rdy;
         logic [7:0] r_in;
         r_en  = 1'($urandom_range(0, 1));
         r_in  = 8'($urandom & $urandom);
         if (($urandom % 5) == 0) r_in = 8'd0;
         r_rdy = (($urandom % 4) != 0);
         cyc(r_en, r_in, r_rdy);
      end

      // counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) cyc(1'b1, 8'hFF, 1'b1);
      check("cnt_sat", int'(bus.cnt), CNT_MAX);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/enc8to3_seq.md
Name: enc8to3_seq

Overview:
- Sequential 8-to-3 event encoder; the inverse of the team's 3-to-8 decoders.
- Captures an 8-bit multi-hot event vector into a pending register and emits one 3-bit index per event over a valid/ready handshake.
- Each index is cleared from pending when it is accepted.
- Sits between event sources (decoded lines, buttons, interrupt-style strobes) and a consumer that handles one index at a time.

Parameters:
- CNT_W, 8, width of the accepted-event counter `cnt`; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0, `in` is ignored.
- in  input  8  event strobes; bit i=1 at an edge (with en=1) marks event i pending.
- rdy  input  1  consumer ready.
- out  output  3  encoded index of the presented event.
- vld  output  1  `out` is valid.
- pending  output  8  current pending register.
- ovf  output  1  sticky: an event arrived while its bit was already pending.
- cnt  output  CNT_W  number of accepted handshakes, saturating.

Behaviour:
- Reset (async, rst=1): out=3'd0, vld=0, pending=8'd0, ovf=0, cnt=0, FSM=IDLE. All outputs are registered.
- Capture, each edge: pending_next = (pending & ~clr_mask) | (en ? in : 8'd0).
  - clr_mask is one-hot of `out` when vld&rdy, else 0.
  - Set wins over clear on the same bit in the same cycle; the bit stays pending.
- ovf is set at an edge when en=1 and (in & pending & ~clr_mask) != 0. It is cleared only by rst.
- FSM states: IDLE, PRESENT.
  - IDLE: if pending != 0, load out = index of lowest set bit of pending, set vld=1, go to PRESENT. Else stay with vld=0.
  - PRESENT, vld&rdy: the bit is cleared this edge and cnt increments (saturating).
    - If (pending & ~clr_mask) != 0, load the next lowest index, keep vld=1, stay in PRESENT. This gives back-to-back issue at one index per cycle.
    - Otherwise vld=0 and go to IDLE.
  - PRESENT, rdy=0: out and vld hold stable, even if a lower-index event arrives.
- Latency: a strobe at edge k makes pending[i]=1 after edge k. vld/out reflect it after edge k+1 when the FSM is IDLE (2-edge latency from strobe to vld).
- Priority: fixed, lowest index first. in=8'b0 with en=1 changes nothing.
- Reset mid-operation: pending, ovf and cnt are lost. vld drops immediately (async). No index is issued until new events are captured after rst deasserts.
- Encoding rule: out is always an index whose pending bit was 1 when it was loaded. vld=1 implies pending[out]=1.

Optional Feature:
- Macro: ENC8TO3_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A 3-bit last-served register (reset 3'd7) records `out` on each accepted handshake.
  - The next index loaded is the first set pending bit searched upward from last+1, wrapping 7→0.
  - With reset value 7, the first search starts at bit 0.
- Undefined: fixed lowest-index-first priority; no last-served register is synthesised.

Test Plan:
- Reset: rst=1 mid-stream with vld=1 → vld=0, pending=0, cnt=0, ovf=0 immediately. After rst drops, with no input, vld stays 0.
- Single event: en=1, in=8'b0010_0000 for one cycle, rdy=1 → vld=1, out=3'd5 two edges later for exactly one cycle. Then pending=0 and cnt=1.
- Multi-hot burst: in=8'b1000_1010 once, rdy=1 → out sequence 1,3,7 on consecutive cycles with vld continuously 1, then vld=0, cnt=3.
- Backpressure and hold: pending=8'b0000_1000 presented (out=3), rdy=0; inject in=8'b0000_0001 → out stays 3 until rdy=1. The next index is 0.
- Overflow and set-wins: bit 2 pending; strobe in[2]=1 → ovf=1. With out=2 accepted and in[2]=1 on the same edge → pending[2] stays 1 and index 2 is issued again.
- Round robin (macro defined): pending=8'hFF, rdy=1 → out 0,1,2,...,7. Re-strobe 8'b0000_0011 after serving 0 → next index is 1, then 2..7, then 0.
